// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types for the MIPS memory / write-back stage
// Holds the wait-FSM state encoding, datapath widths and the MEM/WB bundle.
package mips_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic            memtoreg;
    logic            misalign;
    logic            buserr;
    logic [XLEN-1:0] aluout;
    logic [XLEN-1:0] readdata;
    logic [REGW-1:0] writereg;
    logic [XLEN-1:0] instr;
  } wb_bundle_t;

endpackage

// File: rtl/mem_wait_ctrl.sv
// rtl/mem_wait_ctrl.sv - data-memory handshake FSM with bounded wait counter
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   access       aligned load/store present in the MEM slot
//   dmem_ready   memory accepted/completed the request this cycle
//   stall_m      hold upstream stages this cycle
//   dmem_req     memory request (forced low during reset)
//   complete     request finishes on this edge
//   abort        request gives up on this edge (bus error)
module mem_wait_ctrl
  import mips_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic access,
  input  logic dmem_ready,
  output logic stall_m,
  output logic dmem_req,
  output logic complete,
  output logic abort
);

  localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);

  mem_state_e state;
  logic [7:0] cnt;
  logic       req_raw;

  always_comb begin
    req_raw  = 1'b0;
    stall_m  = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: begin
        req_raw  = access;
        complete = access & dmem_ready;
        stall_m  = access & ~dmem_ready;
      end
      WAIT: begin
        req_raw  = 1'b1;
        complete = dmem_ready;
        abort    = ~dmem_ready & (cnt == LAST);
        // The abort cycle releases the stall so the faulting instruction
        // retires into WB instead of being re-issued from a held EX/MEM.
        stall_m  = ~dmem_ready & ~abort;
      end
      default: begin
        req_raw = 1'b0;
      end
    endcase
  end

  assign dmem_req = req_raw & rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (stall_m) begin
            state <= WAIT;
            cnt   <= 8'd0;
          end
        end
        WAIT: begin
          if (complete || abort) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MIPS memory stage plus MEM/WB pipeline register
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   valid_m .. instr_m               EX/MEM outputs (control, address, data)
//   stall_m                          hold EX/MEM and earlier stages
//   dmem_req/we/addr/wdata           data-memory request port
//   dmem_ready, dmem_rdata           data-memory response
//   valid_w .. writereg_w            registered write-back bundle
//   result_w                         memtoreg_w ? readdata_w : aluout_w
//   misalign_w, buserr_w             exception flags for the WB instruction
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_m,
  input  logic            regwrite_m,
  input  logic            memtoreg_m,
  input  logic            memwrite_m,
  input  logic [XLEN-1:0] aluout_m,
  input  logic [XLEN-1:0] writedata_m,
  input  logic [REGW-1:0] writereg_m,
  input  logic [XLEN-1:0] instr_m,
  output logic            stall_m,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            valid_w,
  output logic            regwrite_w,
  output logic            memtoreg_w,
  output logic [XLEN-1:0] aluout_w,
  output logic [XLEN-1:0] readdata_w,
  output logic [XLEN-1:0] result_w,
  output logic [XLEN-1:0] instr_w,
  output logic [REGW-1:0] writereg_w,
  output logic            misalign_w,
  output logic            buserr_w
);

  logic       mem_op;
  logic       aligned;
  logic       access;
  logic       misalign;
  logic       complete;
  logic       abort;
  wb_bundle_t wb_d;
  wb_bundle_t wb_q;

  assign mem_op   = valid_m & (memtoreg_m | memwrite_m);
  assign aligned  = (aluout_m[1:0] == 2'b00);
  assign access   = mem_op & aligned;
  assign misalign = mem_op & ~aligned;

  mem_wait_ctrl #(
    .MAX_WAIT(MAX_WAIT)
  ) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .access    (access),
    .dmem_ready(dmem_ready),
    .stall_m   (stall_m),
    .dmem_req  (dmem_req),
    .complete  (complete),
    .abort     (abort)
  );

  assign dmem_we    = dmem_req & memwrite_m;
  assign dmem_addr  = aluout_m;
  assign dmem_wdata = writedata_m;

  // Stalled cycles and empty slots both enter WB as an all-zero bubble.
  always_comb begin
    wb_d = '0;
    if (valid_m && !stall_m) begin
      wb_d.valid    = 1'b1;
      wb_d.regwrite = regwrite_m & ~misalign & ~abort;
      wb_d.memtoreg = memtoreg_m;
      wb_d.misalign = misalign;
      wb_d.buserr   = abort;
      wb_d.aluout   = aluout_m;
      wb_d.readdata = (complete && memtoreg_m && !memwrite_m) ? dmem_rdata : '0;
      wb_d.writereg = writereg_m;
      wb_d.instr    = instr_m;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  assign valid_w    = wb_q.valid;
  assign regwrite_w = wb_q.regwrite;
  assign memtoreg_w = wb_q.memtoreg;
  assign misalign_w = wb_q.misalign;
  assign buserr_w   = wb_q.buserr;
  assign aluout_w   = wb_q.aluout;
  assign readdata_w = wb_q.readdata;
  assign writereg_w = wb_q.writereg;
  assign instr_w    = wb_q.instr;
  assign result_w   = wb_q.memtoreg ? wb_q.readdata : wb_q.aluout;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_m, regwrite_m, memtoreg_m, memwrite_m;
  logic [31:0] aluout_m, writedata_m, instr_m;
  logic [4:0]  writereg_m;
  logic        stall_m, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        valid_w, regwrite_w, memtoreg_w;
  logic [31:0] aluout_w, readdata_w, result_w, instr_w;
  logic [4:0]  writereg_w;
  logic        misalign_w, buserr_w;

  int passed = 0;
  int total  = 0;

  mem_wb_stage #(.MAX_WAIT(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_m    (valid_m),
    .regwrite_m (regwrite_m),
    .memtoreg_m (memtoreg_m),
    .memwrite_m (memwrite_m),
    .aluout_m   (aluout_m),
    .writedata_m(writedata_m),
    .writereg_m (writereg_m),
    .instr_m    (instr_m),
    .stall_m    (stall_m),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .valid_w    (valid_w),
    .regwrite_w (regwrite_w),
    .memtoreg_w (memtoreg_w),
    .aluout_w   (aluout_w),
    .readdata_w (readdata_w),
    .result_w   (result_w),
    .instr_w    (instr_w),
    .writereg_w (writereg_w),
    .misalign_w (misalign_w),
    .buserr_w   (buserr_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, rw, mtr, mw;
    logic [31:0] alu, wd;
    logic [4:0]  wr;
    logic        ready;
    logic [31:0] rdata;
    logic        e_req, e_we, e_stall, e_valid, e_rw;
    logic [31:0] e_result, e_rdw;
    logic [4:0]  e_wreg;
    logic        e_mis;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      passed++;
  endtask

  task automatic drive(input logic v, input logic rw, input logic mtr, input logic mw,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                       input logic [31:0] ins);
    valid_m = v; regwrite_m = rw; memtoreg_m = mtr; memwrite_m = mw;
    aluout_m = alu; writedata_m = wd; writereg_m = wr; instr_m = ins;
  endtask

  initial begin
    int n;
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 5'd5, 1'b1, 32'hFFFFFFFF,
                1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0, 5'd5, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd8, 1'b1, 32'hDEADBEEF,
                1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 5'd8, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 5'd9, 1'b1, 32'h0BADF00D,
                1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0BADF00D, 32'h0BADF00D, 5'd9, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h42, 32'h0, 5'd10, 1'b1, 32'h12345678,
                1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 5'd10, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd11, 1'b1, 32'hCAFEF00D,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h48, 32'hA5A5A5A5, 5'd0, 1'b1, 32'hFFFF0000,
                1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h48, 32'h0, 5'd0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h47, 32'h1, 5'd3, 1'b1, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h47, 32'h0, 5'd3, 1'b1};

    // Reset with an aligned load presented: request must stay low.
    rst_n = 1'b0;
    dmem_ready = 1'b0; dmem_rdata = 32'h0;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd7, 32'hAAAA0000);
    @(negedge clk); #1;
    chk("reset_req", {31'b0, dmem_req}, 32'h0);
    @(posedge clk); #1;
    chk("reset_valid_w", {31'b0, valid_w}, 32'h0);
    chk("reset_regwrite_w", {31'b0, regwrite_w}, 32'h0);
    chk("reset_result_w", result_w, 32'h0);
    chk("reset_instr_w", instr_w, 32'h0);
    chk("reset_flags", {30'b0, misalign_w, buserr_w}, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle cases, zero-wait memory (vectors 1,2 are back-to-back loads).
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].valid, vecs[i].rw, vecs[i].mtr, vecs[i].mw,
            vecs[i].alu, vecs[i].wd, vecs[i].wr, 32'h1000_0000 + i);
      dmem_ready = vecs[i].ready; dmem_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d_req", i), {31'b0, dmem_req}, {31'b0, vecs[i].e_req});
      chk($sformatf("v%0d_we", i), {31'b0, dmem_we}, {31'b0, vecs[i].e_we});
      chk($sformatf("v%0d_stall", i), {31'b0, stall_m}, {31'b0, vecs[i].e_stall});
      chk($sformatf("v%0d_addr", i), dmem_addr, vecs[i].alu);
      chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].wd);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid_w", i), {31'b0, valid_w}, {31'b0, vecs[i].e_valid});
      chk($sformatf("v%0d_regwrite_w", i), {31'b0, regwrite_w}, {31'b0, vecs[i].e_rw});
      chk($sformatf("v%0d_result_w", i), result_w, vecs[i].e_result);
      chk($sformatf("v%0d_readdata_w", i), readdata_w, vecs[i].e_rdw);
      chk($sformatf("v%0d_writereg_w", i), {27'b0, writereg_w}, {27'b0, vecs[i].e_wreg});
      chk($sformatf("v%0d_misalign_w", i), {31'b0, misalign_w}, {31'b0, vecs[i].e_mis});
      chk($sformatf("v%0d_buserr_w", i), {31'b0, buserr_w}, 32'h0);
      if (vecs[i].e_valid)
        chk($sformatf("v%0d_instr_w", i), instr_w, 32'h1000_0000 + i);
      @(negedge clk);
    end

    // Store at 0x44, memory ready after three stalled cycles.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h44, 32'h55AA55AA, 5'd0, 32'h2000_0001);
    dmem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("st_stall%0d", c), {31'b0, stall_m}, 32'h1);
      chk($sformatf("st_req%0d", c), {29'b0, dmem_req, dmem_we, 1'b0}, 32'h6);
      @(posedge clk); #1;
      chk($sformatf("st_bubble%0d", c), {30'b0, valid_w, regwrite_w}, 32'h0);
      @(negedge clk);
    end
    dmem_ready = 1'b1;
    #1;
    chk("st_done_stall", {31'b0, stall_m}, 32'h0);
    chk("st_done_we", {31'b0, dmem_we}, 32'h1);
    @(posedge clk); #1;
    chk("st_valid_w", {31'b0, valid_w}, 32'h1);
    chk("st_regwrite_w", {31'b0, regwrite_w}, 32'h0);
    chk("st_result_w", result_w, 32'h44);
    chk("st_instr_w", instr_w, 32'h2000_0001);
    @(negedge clk);

    // Load that is never acknowledged: 15 stall cycles then bus error.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h60, 32'h0, 5'd12, 32'h3000_0002);
    dmem_ready = 1'b0; dmem_rdata = 32'h77777777;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!stall_m) break;
      n++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("abort_stall_cycles", n, 32'd15);
    chk("abort_cycle_req", {31'b0, dmem_req}, 32'h1);
    @(posedge clk); #1;
    chk("abort_valid_w", {31'b0, valid_w}, 32'h1);
    chk("abort_buserr_w", {31'b0, buserr_w}, 32'h1);
    chk("abort_regwrite_w", {31'b0, regwrite_w}, 32'h0);
    chk("abort_readdata_w", readdata_w, 32'h0);
    @(negedge clk);
    valid_m = 1'b0;
    #1;
    chk("abort_req_dropped", {31'b0, dmem_req}, 32'h0);
    @(posedge clk);
    @(negedge clk);

    // Reset asserted in the second WAIT cycle of a pending load.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h64, 32'h0, 5'd13, 32'h4000_0003);
    dmem_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_wait_req", {31'b0, dmem_req}, 32'h0);
    @(posedge clk); #1;
    chk("rst_wait_valid_w", {31'b0, valid_w}, 32'h0);
    chk("rst_wait_flags", {29'b0, regwrite_w, misalign_w, buserr_w}, 32'h0);
    chk("rst_wait_result_w", result_w, 32'h0);
    chk("rst_wait_writereg_w", {27'b0, writereg_w}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    valid_m = 1'b0;
    #1;
    chk("rst_wait_fsm_idle", {31'b0, dmem_req}, 32'h0);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd14, 32'h5000_0004);
    @(posedge clk); #1;
    chk("post_rst_result_w", result_w, 32'h1234);
    chk("post_rst_valid_w", {31'b0, valid_w}, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
